// File: rtl/fetch_unit.sv
// Instruction fetch stage: a single-port-write instruction memory plus a registered
// fetch buffer with valid/ready handoff to decode, stall and redirect control.
module fetch_unit #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 1024,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] instruction_buf,
    output logic [ADDR_W-1:0] pc_out
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pc_out_q, pc_out_d;
    logic              fetch_en;

    // Upper address bits alias onto the same entries.
    logic unused_write_addr;
    assign unused_write_addr = ^write_addr;

    // Memory is never reset; writes proceed regardless of control state.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_addr[IDX_W-1:0]] <= write_data;
        end
    end

    // Combinational read sampled at the edge yields read-before-write.
    assign rd_data = mem[pc_q[IDX_W-1:0]];

    always_comb begin
        fetch_en = !stall && !redirect_valid && (!valid_q || out_ready);
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            valid_d = 1'b0;
        end else if (fetch_en) begin
            instr_d  = rd_data;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + ADDR_W'(1);
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= '0;
        end else begin
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
        end
    end

    assign out_valid       = valid_q;
    assign instruction_buf = instr_q;
    assign pc_out          = pc_out_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: load, stream, backpressure, redirect, wrap and
// asynchronous reset, with hand-computed expectations.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        write_enable;
    logic [31:0] write_addr;
    logic [15:0] write_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] instruction_buf;
    logic [31:0] pc_out;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .write_enable   (write_enable),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .instruction_buf(instruction_buf),
        .pc_out         (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [15:0] ins,
                             input logic [31:0] pc);
        check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        check({tag, ".instr"}, {16'd0, instruction_buf}, {16'd0, ins});
        check({tag, ".pc"}, pc_out, pc);
    endtask

    task automatic write_mem(input logic [31:0] a, input logic [15:0] d);
        write_enable = 1'b1;
        write_addr   = a;
        write_data   = d;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        write_enable   = 1'b0;
        write_addr     = '0;
        write_data     = '0;
        stall          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        #2;
        check_out("reset", 1'b0, 16'h0000, 32'h0);

        // Writes during reset must land.
        write_mem(32'h0, 16'h1111);
        write_mem(32'h1, 16'h2222);
        write_mem(32'h2, 16'h3333);
        write_mem(32'h3, 16'h4444);
        write_mem(32'h5, 16'h1234);
        write_mem(32'h10, 16'hABCD);
        write_mem(32'h11, 16'h7777);
        write_mem(32'h3FF, 16'h3FF3);
        check_out("reset_hold", 1'b0, 16'h0000, 32'h0);

        // Out of reset but stalled with nothing valid: hold.
        rst = 1'b0;
        tick();
        check_out("stall_idle", 1'b0, 16'h0000, 32'h0);

        // Streaming from RESET_PC.
        stall     = 1'b0;
        out_ready = 1'b1;
        tick();
        check_out("fetch0", 1'b1, 16'h1111, 32'h0);
        tick();
        check_out("fetch1", 1'b1, 16'h2222, 32'h1);

        // Backpressure freezes everything.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("bp_hold", 1'b1, 16'h2222, 32'h1);
        end
        out_ready = 1'b1;
        tick();
        check_out("bp_release", 1'b1, 16'h3333, 32'h2);

        // Back-to-back redirects under stall and backpressure; last one wins.
        stall     = 1'b1;
        out_ready = 1'b0;
        redirect(32'h20);
        check_out("redir_flush", 1'b0, 16'h3333, 32'h2);
        redirect(32'h10);
        check_out("redir_second", 1'b0, 16'h3333, 32'h2);
        tick();
        check_out("redir_stalled", 1'b0, 16'h3333, 32'h2);
        stall     = 1'b0;
        out_ready = 1'b1;
        tick();
        check_out("redir_target", 1'b1, 16'hABCD, 32'h10);

        // Consumed while stalled: valid drops, PC holds at 0x11.
        stall = 1'b1;
        tick();
        check_out("drain_stall", 1'b0, 16'hABCD, 32'h10);
        stall = 1'b0;
        tick();
        check_out("pc_held", 1'b1, 16'h7777, 32'h11);

        // Write and fetch hit index 5 in the same cycle: old data read.
        redirect(32'h5);
        write_enable = 1'b1;
        write_addr   = 32'h5;
        write_data   = 16'h9999;
        tick();
        write_enable = 1'b0;
        check_out("rbw_old", 1'b1, 16'h1234, 32'h5);
        redirect(32'h5);
        tick();
        check_out("rbw_new", 1'b1, 16'h9999, 32'h5);

        // Address aliasing and PC wrap.
        stall = 1'b1;
        write_mem(32'h0, 16'h5A5A);
        stall = 1'b0;
        redirect(32'h400);
        tick();
        check_out("alias", 1'b1, 16'h5A5A, 32'h400);
        redirect(32'hFFFF_FFFF);
        tick();
        check_out("pc_max", 1'b1, 16'h3FF3, 32'hFFFF_FFFF);
        tick();
        check_out("pc_wrap", 1'b1, 16'h5A5A, 32'h0);

        // Asynchronous reset between edges while valid.
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 16'h0000, 32'h0);
        tick();
        check_out("async_rst_hold", 1'b0, 16'h0000, 32'h0);
        rst = 1'b0;
        tick();
        check_out("post_rst0", 1'b1, 16'h5A5A, 32'h0);
        tick();
        check_out("post_rst1", 1'b1, 16'h2222, 32'h1);
        tick();
        check_out("post_rst2", 1'b1, 16'h3333, 32'h2);
        redirect(32'h5);
        tick();
        check_out("post_rst_mem5", 1'b1, 16'h9999, 32'h5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
